tgmux_scan_ctrl: RTL

Clocked scan controller and registered data path for an N-channel, W-bit transmission-gate multiplexer array. It generalises the fixed 2:1 / 8-bit TG mux into a parametrised N:1 mux with its own select sequencing. It also models select settling time and delivers one captured sample per channel over a valid/ready handshake. It sits between the neuron input arrays and the downstream accumulator, and replaces the external pattern-generated select.

---
 rtl/tgmux_pkg.sv | 44 ++++
 rtl/tgmux_nsel.sv | 22 ++
 rtl/tgmux_scan_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/tgmux_pkg.sv
// rtl/tgmux_pkg.sv - shared modes, state codes and mask search helper for the TG mux scanner
package tgmux_pkg;

  typedef enum logic [1:0] {
    MODE_FIXED = 2'd0,
    MODE_RR    = 2'd1,
    MODE_MASK  = 2'd2,
    MODE_SWEEP = 2'd3
  } mode_e;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_SWITCH = 3'd1;
  localparam state_t ST_SAMPLE = 3'd2;
  localparam state_t ST_HOLD   = 3'd3;
  localparam state_t ST_NEXT   = 3'd4;

  // Result of a circular mask search: found index, whether the search passed
  // the top of the mask (index at or below the start point), and whether any bit is set.
  typedef struct packed {
    logic [3:0] idx;
    logic       wrap;
    logic       found;
  } nsb_t;

  // Next set bit strictly above cur, circularly; a single set bit equal to cur is found last.
  // Called with cur = 4'hF this returns the lowest set bit of the mask.
  function automatic nsb_t next_set_bit(input logic [15:0] mask, input logic [3:0] cur);
    nsb_t       r;
    logic [3:0] j;
    r = '0;
    for (int i = 1; i <= 16; i++) begin
      j = cur + 4'(i);
      if (!r.found && mask[j]) begin
        r.found = 1'b1;
        r.idx   = j;
        r.wrap  = (j <= cur);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tgmux_nsel.sv
// rtl/tgmux_nsel.sv - combinational WIDTH-bit N:1 select on a flattened channel bus
module tgmux_nsel
  import tgmux_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int WIDTH = 8,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data
);

  // Exactly one channel passes; a select outside 0..NCH-1 passes nothing
  always_comb begin
    out_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (sel == SELW'(k)) out_data = in_data[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/tgmux_scan_ctrl.sv
// rtl/tgmux_scan_ctrl.sv - select sequencer, settle timer and sample handshake for the TG mux array
module tgmux_scan_ctrl
  import tgmux_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int WIDTH  = 8,
  parameter int SETTLE = 2,
  localparam int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic [SELW-1:0]      fix_sel,
  input  logic [NCH-1:0]       ch_mask,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 scan_done,
  output logic                 busy
);

  localparam logic [SELW-1:0] LAST_CH     = SELW'(NCH - 1);
  // SWITCH always lasts at least one cycle, so SETTLE of 0 and 1 share the same last count
  localparam logic [3:0]      SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

  state_t           state;
  logic [SELW-1:0]  sel_q;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] mux_data;
  logic [SELW-1:0]  fix_ch;
  logic [15:0]      mask16;
  nsb_t             first_hit;
  nsb_t             next_hit;
  logic             unused_bits;

  // Out-of-range fixed selects (NCH not a power of two) clamp to the last real channel
  assign fix_ch    = (int'(fix_sel) < NCH) ? fix_sel : LAST_CH;
  assign mask16    = 16'(ch_mask);
  assign first_hit = next_set_bit(mask16, 4'hF);
  assign next_hit  = next_set_bit(mask16, 4'(sel_q));

  assign unused_bits = ^{first_hit.wrap, first_hit.idx, next_hit.idx};

  assign sel  = sel_q;
  assign busy = (state != ST_IDLE);

  tgmux_nsel #(
    .NCH   (NCH),
    .WIDTH (WIDTH),
    .SELW  (SELW)
  ) u_nsel (
    .in_data  (in_data),
    .sel      (sel_q),
    .out_data (mux_data)
  );

  // Scan sequencing, settle counting, capture register and output handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      sel_q     <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      scan_done <= 1'b0;
    end else if (!en) begin
      // Abort: any pending sample is dropped and no sweep end is reported
      state     <= ST_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          case (mode_e'(mode))
            MODE_FIXED: begin
              sel_q <= fix_ch;
              state <= ST_SWITCH;
            end
            MODE_RR: begin
              sel_q <= '0;
              state <= ST_SWITCH;
            end
            default: begin
              if (first_hit.found) begin
                sel_q <= first_hit.idx[SELW-1:0];
                state <= ST_SWITCH;
              end
            end
          endcase
        end

        ST_SWITCH: begin
          if (cnt >= SETTLE_LAST) begin
            cnt   <= '0;
            state <= ST_SAMPLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        ST_SAMPLE: begin
          out_data  <= mux_data;
          out_ch    <= sel_q;
          out_valid <= 1'b1;
          state     <= ST_HOLD;
        end

        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_NEXT;
          end
        end

        ST_NEXT: begin
          case (mode_e'(mode))
            MODE_FIXED: begin
              // Same channel needs no settling, a new one does
              sel_q <= fix_ch;
              state <= (fix_ch == sel_q) ? ST_SAMPLE : ST_SWITCH;
            end
            MODE_RR: begin
              if (sel_q == LAST_CH) begin
                sel_q     <= '0;
                scan_done <= 1'b1;
              end else begin
                sel_q <= sel_q + SELW'(1);
              end
              state <= ST_SWITCH;
            end
            default: begin
              if (!next_hit.found) begin
                state <= ST_IDLE;
              end else begin
                sel_q     <= next_hit.idx[SELW-1:0];
                scan_done <= next_hit.wrap;
                state     <= (next_hit.wrap && mode == MODE_SWEEP) ? ST_IDLE : ST_SWITCH;
              end
            end
          endcase
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
